// File: rtl/obi_xbar_pkg.sv
// obi_xbar_pkg: shared types and the default address map for the OBI crossbar.
//   obi_req_t : manager request bundle (req, addr, we, be, wdata)
//   obi_rsp_t : manager response bundle (gnt, rvalid, rdata, err)
//   *_BASE_ADDR / *_END_ADDR : inclusive windows of the default subordinates
//   (index 0 btld, 1 periph, 2 flash, 3 sram).
package obi_xbar_pkg;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        err;
   } obi_rsp_t;

   localparam logic [31:0] BTLD_BASE_ADDR   = 32'h0000_1000;
   localparam logic [31:0] BTLD_END_ADDR    = 32'h0000_1FFF;
   localparam logic [31:0] PERIPH_BASE_ADDR = 32'h1000_0000;
   localparam logic [31:0] PERIPH_END_ADDR  = 32'h1000_1FFF;
   localparam logic [31:0] FLASH_BASE_ADDR  = 32'h2000_0000;
   localparam logic [31:0] FLASH_END_ADDR   = 32'h3FFF_FFFF;
   localparam logic [31:0] SRAM_BASE_ADDR   = 32'h8000_0000;
   localparam logic [31:0] SRAM_END_ADDR    = 32'h8000_FFFF;

endpackage

// File: rtl/obi_xbar_nxm_if.sv
// obi_xbar_nxm_if: bundle of every crossbar-facing bus signal except clock
// and reset, so a system (or bench) can carry the whole fabric as one object.
//   master : view of the side that drives manager requests and subordinate
//            responses into the crossbar
//   slave  : view of the crossbar itself
interface obi_xbar_nxm_if #(
   parameter int unsigned N_MGR = 2,
   parameter int unsigned N_SUB = 4
);
   logic [N_MGR-1:0]    mgr_req;
   logic [N_MGR-1:0]    mgr_gnt;
   logic [N_MGR*32-1:0] mgr_addr;
   logic [N_MGR-1:0]    mgr_we;
   logic [N_MGR*4-1:0]  mgr_be;
   logic [N_MGR*32-1:0] mgr_wdata;
   logic [N_MGR-1:0]    mgr_rvalid;
   logic [N_MGR*32-1:0] mgr_rdata;
   logic [N_MGR-1:0]    mgr_err;
   logic [N_SUB-1:0]    sub_req;
   logic [N_SUB-1:0]    sub_gnt;
   logic [N_SUB*32-1:0] sub_addr;
   logic [N_SUB*32-1:0] sub_wdata;
   logic [N_SUB-1:0]    sub_we;
   logic [N_SUB*4-1:0]  sub_be;
   logic [N_SUB-1:0]    sub_rvalid;
   logic [N_SUB*32-1:0] sub_rdata;
   logic                illegal_access;

   modport master (
      output mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata,
             sub_gnt, sub_rvalid, sub_rdata,
      input  mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
             sub_req, sub_addr, sub_wdata, sub_we, sub_be, illegal_access
   );

   modport slave (
      input  mgr_req, mgr_addr, mgr_we, mgr_be, mgr_wdata,
             sub_gnt, sub_rvalid, sub_rdata,
      output mgr_gnt, mgr_rvalid, mgr_rdata, mgr_err,
             sub_req, sub_addr, sub_wdata, sub_we, sub_be, illegal_access
   );
endinterface

// File: rtl/obi_rr_arb.sv
// obi_rr_arb: round-robin arbiter for one subordinate.
//   clk, rst_n : clock, async active-low reset (pointer returns to 0)
//   req        : eligible requesters
//   advance    : handshake happened; pointer moves to winner+1 mod N
//   idx, valid : combinational winner index and "some request present"
module obi_rr_arb #(
   parameter int unsigned N = 2,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW-1:0] ptr;

   // Rotate the request vector so the pointer position sits at bit 0, take
   // the first set bit, then add the pointer back modulo N.
   always_comb begin
      logic [2*N-1:0] dbl;
      logic [IW:0]    sum;
      dbl   = {req, req} >> ptr;
      sum   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!valid && dbl[i]) begin
            valid = 1'b1;
            sum   = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
            idx   = sum[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/obi_xbar_nxm.sv
// obi_xbar_nxm: N-manager x M-subordinate OBI crossbar.
//   clk_i, rst_ni            : clock, async active-low reset
//   mgr_req/addr/we/be/wdata : manager request channel (inputs)
//   mgr_gnt/rvalid/rdata/err : manager response channel (outputs)
//   sub_req/addr/we/be/wdata : subordinate request channel (outputs)
//   sub_gnt/rvalid/rdata     : subordinate response channel (inputs)
//   illegal_access_o         : spurious response, or pending unmapped request
// Optional feature: define OBI_XBAR_ERR_RESP_EN to answer unmapped requests
// with an error response one cycle after grant instead of stalling them.
module obi_xbar_nxm
   import obi_xbar_pkg::*;
#(
   parameter int unsigned         N_MGR         = 2,
   parameter int unsigned         N_SUB         = 4,
   parameter int unsigned         MAX_OUTST     = 2,
   parameter logic [N_SUB*32-1:0] SUB_BASE_ADDR = {SRAM_BASE_ADDR, FLASH_BASE_ADDR,
                                                   PERIPH_BASE_ADDR, BTLD_BASE_ADDR},
   parameter logic [N_SUB*32-1:0] SUB_END_ADDR  = {SRAM_END_ADDR, FLASH_END_ADDR,
                                                   PERIPH_END_ADDR, BTLD_END_ADDR}
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_MGR-1:0]    mgr_req_i,
   output logic [N_MGR-1:0]    mgr_gnt_o,
   input  logic [N_MGR*32-1:0] mgr_addr_i,
   input  logic [N_MGR-1:0]    mgr_we_i,
   input  logic [N_MGR*4-1:0]  mgr_be_i,
   input  logic [N_MGR*32-1:0] mgr_wdata_i,
   output logic [N_MGR-1:0]    mgr_rvalid_o,
   output logic [N_MGR*32-1:0] mgr_rdata_o,
   output logic [N_MGR-1:0]    mgr_err_o,
   output logic [N_SUB-1:0]    sub_req_o,
   input  logic [N_SUB-1:0]    sub_gnt_i,
   output logic [N_SUB*32-1:0] sub_addr_o,
   output logic [N_SUB*32-1:0] sub_wdata_o,
   output logic [N_SUB-1:0]    sub_we_o,
   output logic [N_SUB*4-1:0]  sub_be_o,
   input  logic [N_SUB-1:0]    sub_rvalid_i,
   input  logic [N_SUB*32-1:0] sub_rdata_i,
   output logic                illegal_access_o
);

   localparam int unsigned IDW   = (N_MGR > 1) ? $clog2(N_MGR) : 1;
   localparam int unsigned TW    = $clog2(N_SUB + 1);
   localparam int unsigned CW    = $clog2(MAX_OUTST + 1);
   localparam int unsigned DEPTH = N_MGR * MAX_OUTST;
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned FCW   = $clog2(DEPTH + 1);

   obi_req_t         mreq     [N_MGR];
   obi_rsp_t         mrsp     [N_MGR];
   logic [TW-1:0]    tgt      [N_MGR];
   logic [TW-1:0]    last_tgt [N_MGR];
   logic [CW-1:0]    cnt      [N_MGR];
   logic [N_MGR-1:0] unmapped;
   logic [N_MGR-1:0] elig;

   logic [IDW-1:0]   win  [N_SUB];
   logic [IDW-1:0]   head [N_SUB];
   logic [N_SUB-1:0] win_vld;
   logic [N_SUB-1:0] hs;
   logic [N_SUB-1:0] fifo_empty;
   logic [N_SUB-1:0] pop;
   logic [N_SUB-1:0] spurious;

`ifdef OBI_XBAR_ERR_RESP_EN
   logic [N_MGR-1:0] err_pend;
`endif

   // Decode (descending scan so the lowest overlapping window wins) and
   // eligibility: a manager with traffic in flight may only keep talking to
   // the same target, which keeps its responses in order.
   always_comb begin
      mreq     = '{default: '0};
      tgt      = '{default: '0};
      unmapped = '0;
      elig     = '0;
      for (int unsigned m = 0; m < N_MGR; m++) begin
         mreq[m].req   = mgr_req_i[m];
         mreq[m].addr  = mgr_addr_i[m*32 +: 32];
         mreq[m].we    = mgr_we_i[m];
         mreq[m].be    = mgr_be_i[m*4 +: 4];
         mreq[m].wdata = mgr_wdata_i[m*32 +: 32];
         tgt[m]        = TW'(N_SUB);
         for (int unsigned k = N_SUB; k > 0; k--) begin
            if (mreq[m].addr >= SUB_BASE_ADDR[(k-1)*32 +: 32] &&
                mreq[m].addr <= SUB_END_ADDR[(k-1)*32 +: 32])
               tgt[m] = TW'(k - 1);
         end
         unmapped[m] = (tgt[m] == TW'(N_SUB));
         elig[m]     = rst_ni && mreq[m].req && (cnt[m] < CW'(MAX_OUTST)) &&
                       ((cnt[m] == '0) || (tgt[m] == last_tgt[m]));
      end
   end

   for (genvar s = 0; s < N_SUB; s++) begin : g_sub
      logic [N_MGR-1:0] arb_req;
      logic [IDW-1:0]   mem [DEPTH];
      logic [PW-1:0]    wptr;
      logic [PW-1:0]    rptr;
      logic [FCW-1:0]   fcnt;

      always_comb begin
         arb_req = '0;
         for (int unsigned m = 0; m < N_MGR; m++)
            arb_req[m] = elig[m] && (tgt[m] == TW'(s));
      end

      obi_rr_arb #(.N(N_MGR)) u_arb (
         .clk     (clk_i),
         .rst_n   (rst_ni),
         .req     (arb_req),
         .advance (hs[s]),
         .idx     (win[s]),
         .valid   (win_vld[s])
      );

      assign hs[s]         = win_vld[s] & sub_gnt_i[s];
      assign fifo_empty[s] = (fcnt == '0);
      assign head[s]       = mem[rptr];

      // ID FIFO: which manager owns each outstanding transaction here.
      always_ff @(posedge clk_i) begin
         if (hs[s]) mem[wptr] <= win[s];
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            fcnt <= '0;
         end else begin
            if (hs[s])  wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (pop[s]) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            if (hs[s] && !pop[s])      fcnt <= fcnt + 1'b1;
            else if (!hs[s] && pop[s]) fcnt <= fcnt - 1'b1;
         end
      end
   end

   // Subordinate request channel: winner's fields, zero when nobody wins.
   always_comb begin
      sub_req_o   = '0;
      sub_we_o    = '0;
      sub_be_o    = '0;
      sub_addr_o  = '0;
      sub_wdata_o = '0;
      for (int unsigned s = 0; s < N_SUB; s++) begin
         if (win_vld[s]) begin
            sub_req_o[s]          = 1'b1;
            sub_we_o[s]           = mreq[win[s]].we;
            sub_be_o[s*4 +: 4]    = mreq[win[s]].be;
            sub_addr_o[s*32 +: 32]  = mreq[win[s]].addr;
            sub_wdata_o[s*32 +: 32] = mreq[win[s]].wdata;
         end
      end
   end

   // Grants and response routing back to managers.
   always_comb begin
      mrsp     = '{default: '0};
      pop      = '0;
      spurious = '0;
      for (int unsigned s = 0; s < N_SUB; s++) begin
         for (int unsigned m = 0; m < N_MGR; m++) begin
            if (hs[s] && win[s] == IDW'(m)) mrsp[m].gnt = 1'b1;
         end
         if (rst_ni && sub_rvalid_i[s]) begin
            if (fifo_empty[s]) begin
               spurious[s] = 1'b1;
            end else begin
               pop[s] = 1'b1;
               for (int unsigned m = 0; m < N_MGR; m++) begin
                  if (head[s] == IDW'(m)) begin
                     mrsp[m].rvalid = 1'b1;
                     mrsp[m].rdata  = sub_rdata_i[s*32 +: 32];
                  end
               end
            end
         end
      end
`ifdef OBI_XBAR_ERR_RESP_EN
      for (int unsigned m = 0; m < N_MGR; m++) begin
         if (elig[m] && unmapped[m]) mrsp[m].gnt = 1'b1;
         if (err_pend[m]) begin
            mrsp[m].rvalid = 1'b1;
            mrsp[m].err    = 1'b1;
            mrsp[m].rdata  = '0;
         end
      end
`endif
   end

   always_comb begin
      mgr_gnt_o    = '0;
      mgr_rvalid_o = '0;
      mgr_rdata_o  = '0;
      mgr_err_o    = '0;
      for (int unsigned m = 0; m < N_MGR; m++) begin
         mgr_gnt_o[m]           = mrsp[m].gnt;
         mgr_rvalid_o[m]        = mrsp[m].rvalid;
         mgr_rdata_o[m*32 +: 32] = mrsp[m].rdata;
         mgr_err_o[m]           = mrsp[m].err;
      end
   end

   always_comb begin
      illegal_access_o = |spurious;
`ifndef OBI_XBAR_ERR_RESP_EN
      if (rst_ni && (|(mgr_req_i & unmapped))) illegal_access_o = 1'b1;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned m = 0; m < N_MGR; m++) begin
            cnt[m]      <= '0;
            last_tgt[m] <= '0;
         end
      end else begin
         for (int unsigned m = 0; m < N_MGR; m++) begin
            if (mrsp[m].gnt && !mrsp[m].rvalid)      cnt[m] <= cnt[m] + 1'b1;
            else if (!mrsp[m].gnt && mrsp[m].rvalid) cnt[m] <= cnt[m] - 1'b1;
            if (mrsp[m].gnt) last_tgt[m] <= tgt[m];
         end
      end
   end

`ifdef OBI_XBAR_ERR_RESP_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_pend <= '0;
      else         err_pend <= elig & unmapped;
   end
`endif

endmodule

// File: tb/tb_obi_xbar_nxm.sv
// tb_obi_xbar_nxm: directed self-checking bench for obi_xbar_nxm
// (2 managers, default 4-subordinate map, MAX_OUTST = 2).
module tb_obi_xbar_nxm;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   obi_xbar_nxm_if #(.N_MGR(2), .N_SUB(4)) bus ();

   obi_xbar_nxm #(.N_MGR(2), .N_SUB(4), .MAX_OUTST(2)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .mgr_req_i        (bus.mgr_req),
      .mgr_gnt_o        (bus.mgr_gnt),
      .mgr_addr_i       (bus.mgr_addr),
      .mgr_we_i         (bus.mgr_we),
      .mgr_be_i         (bus.mgr_be),
      .mgr_wdata_i      (bus.mgr_wdata),
      .mgr_rvalid_o     (bus.mgr_rvalid),
      .mgr_rdata_o      (bus.mgr_rdata),
      .mgr_err_o        (bus.mgr_err),
      .sub_req_o        (bus.sub_req),
      .sub_gnt_i        (bus.sub_gnt),
      .sub_addr_o       (bus.sub_addr),
      .sub_wdata_o      (bus.sub_wdata),
      .sub_we_o         (bus.sub_we),
      .sub_be_o         (bus.sub_be),
      .sub_rvalid_i     (bus.sub_rvalid),
      .sub_rdata_i      (bus.sub_rdata),
      .illegal_access_o (bus.illegal_access)
   );

   task automatic idle();
      bus.mgr_req    = '0;
      bus.mgr_addr   = '0;
      bus.mgr_we     = '0;
      bus.mgr_be     = '0;
      bus.mgr_wdata  = '0;
      bus.sub_gnt    = '0;
      bus.sub_rvalid = '0;
      bus.sub_rdata  = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle();
      bus.mgr_req = 2'b11;
      bus.mgr_addr = {32'h2000_0000, 32'h8000_0010};
      bus.sub_gnt = 4'hF;
      bus.sub_rvalid = 4'hF;
      #1;
      n_cmp++; if (bus.mgr_gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", bus.mgr_gnt); end
      n_cmp++; if (bus.mgr_rvalid !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", bus.mgr_rvalid); end
      n_cmp++; if (bus.sub_req !== 4'h0) begin n_err++; $display("FAIL rst_sub_req: got %b want 0000", bus.sub_req); end
      n_cmp++; if (bus.sub_addr !== 128'h0) begin n_err++; $display("FAIL rst_sub_addr: got %h want 0", bus.sub_addr); end
      n_cmp++; if (bus.illegal_access !== 1'b0) begin n_err++; $display("FAIL rst_illegal: got %b want 0", bus.illegal_access); end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      @(negedge clk);
      idle();
      bus.mgr_req[0] = 1'b1;
      bus.mgr_addr[31:0] = 32'h8000_0010;
      bus.mgr_be[3:0] = 4'hF;
      bus.sub_gnt = 4'b1000;
      #1;
      n_cmp++; if (bus.mgr_gnt !== 2'b01) begin n_err++; $display("FAIL rd_gnt: got %b want 01", bus.mgr_gnt); end
      n_cmp++; if (bus.sub_req !== 4'b1000) begin n_err++; $display("FAIL rd_sub_req: got %b want 1000", bus.sub_req); end
      n_cmp++; if (bus.sub_addr[127:96] !== 32'h8000_0010) begin n_err++; $display("FAIL rd_sub_addr: got %h want 80000010", bus.sub_addr[127:96]); end
      n_cmp++; if (bus.sub_be[15:12] !== 4'hF) begin n_err++; $display("FAIL rd_sub_be: got %h want f", bus.sub_be[15:12]); end
      n_cmp++; if (bus.sub_we !== 4'h0) begin n_err++; $display("FAIL rd_sub_we: got %b want 0000", bus.sub_we); end
      @(negedge clk);
      idle();
      bus.sub_rvalid[3] = 1'b1;
      bus.sub_rdata[127:96] = 32'hCAFE_0001;
      #1;
      n_cmp++; if (bus.mgr_rvalid !== 2'b01) begin n_err++; $display("FAIL rd_rvalid: got %b want 01", bus.mgr_rvalid); end
      n_cmp++; if (bus.mgr_rdata[31:0] !== 32'hCAFE_0001) begin n_err++; $display("FAIL rd_rdata0: got %h want cafe0001", bus.mgr_rdata[31:0]); end
      n_cmp++; if (bus.mgr_rdata[63:32] !== 32'h0) begin n_err++; $display("FAIL rd_rdata1: got %h want 0", bus.mgr_rdata[63:32]); end
      n_cmp++; if (bus.mgr_err !== 2'b00) begin n_err++; $display("FAIL rd_err: got %b want 00", bus.mgr_err); end
      n_cmp++; if (bus.mgr_gnt !== 2'b00) begin n_err++; $display("FAIL rd_gnt_idle: got %b want 00", bus.mgr_gnt); end
      @(negedge clk);
      idle();
      #1;
      n_cmp++; if (bus.mgr_rvalid !== 2'b00) begin n_err++; $display("FAIL rd_rvalid_after: got %b want 00", bus.mgr_rvalid); end
      n_cmp++; if (bus.mgr_rdata !== 64'h0) begin n_err++; $display("FAIL rd_rdata_after: got %h want 0", bus.mgr_rdata); end
   endtask

   task automatic test_decode_bounds();
      logic [31:0] addrs [4];
      logic [3:0]  exps  [4];
      addrs = '{32'h0000_1000, 32'h1000_1FFF, 32'h3FFF_FFFF, 32'h8000_FFFF};
      exps  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idle();
         bus.mgr_req[0] = 1'b1;
         bus.mgr_addr[31:0] = addrs[i];
         #1;
         n_cmp++; if (bus.sub_req !== exps[i]) begin n_err++; $display("FAIL dec_sub_req[%0d]: got %b want %b", i, bus.sub_req, exps[i]); end
         n_cmp++; if (bus.mgr_gnt !== 2'b00) begin n_err++; $display("FAIL dec_no_gnt[%0d]: got %b want 00", i, bus.mgr_gnt); end
      end
   endtask

   task automatic test_contention();
      logic [1:0]  exp_g;
      logic [1:0]  exp_r;
      logic [31:0] exp_a;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         idle();
         bus.mgr_req = 2'b11;
         bus.mgr_addr = {32'h2000_0100, 32'h2000_0000};
         bus.mgr_we = 2'b10;
         bus.mgr_wdata = {32'h1111_2222, 32'h0};
         bus.sub_gnt[2] = 1'b1;
         if (i > 0) begin
            bus.sub_rvalid[2] = 1'b1;
            bus.sub_rdata[95:64] = 32'hF000_0000 + i;
         end
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_r = (i % 2 == 0) ? 2'b10 : 2'b01;
         exp_a = (i % 2 == 0) ? 32'h2000_0000 : 32'h2000_0100;
         #1;
         n_cmp++; if (bus.mgr_gnt !== exp_g) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, bus.mgr_gnt, exp_g); end
         n_cmp++; if (bus.sub_addr[95:64] !== exp_a) begin n_err++; $display("FAIL rr_addr[%0d]: got %h want %h", i, bus.sub_addr[95:64], exp_a); end
         n_cmp++; if (bus.sub_we[2] !== exp_g[1]) begin n_err++; $display("FAIL rr_we[%0d]: got %b want %b", i, bus.sub_we[2], exp_g[1]); end
         if (i > 0) begin
            n_cmp++; if (bus.mgr_rvalid !== exp_r) begin n_err++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, bus.mgr_rvalid, exp_r); end
            n_cmp++; if (bus.mgr_rdata !== (exp_r[0] ? {32'h0, 32'hF000_0000 + i} : {32'hF000_0000 + i, 32'h0}))
               begin n_err++; $display("FAIL rr_rdata[%0d]: got %h", i, bus.mgr_rdata); end
         end
      end
      @(negedge clk);
      idle();
      bus.sub_rvalid[2] = 1'b1;
      bus.sub_rdata[95:64] = 32'hF000_0004;
      #1;
      n_cmp++; if (bus.mgr_rvalid !== 2'b10) begin n_err++; $display("FAIL rr_last_rvalid: got %b want 10", bus.mgr_rvalid); end
      n_cmp++; if (bus.mgr_rdata[63:32] !== 32'hF000_0004) begin n_err++; $display("FAIL rr_last_rdata: got %h want f0000004", bus.mgr_rdata[63:32]); end
   endtask

   task automatic test_order_stall();
      @(negedge clk);
      idle();
      bus.mgr_req[0] = 1'b1;
      bus.mgr_addr[31:0] = 32'h8000_0020;
      bus.sub_gnt = 4'b1000;
      #1;
      n_cmp++; if (bus.mgr_gnt !== 2'b01) begin n_err++; $display("FAIL st_sram_gnt: got %b want 01", bus.mgr_gnt); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         bus.mgr_req[0] = 1'b1;
         bus.mgr_addr[31:0] = 32'h2000_0040;
         bus.sub_gnt = 4'b0100;
         if (i == 2) begin
            bus.sub_rvalid[3] = 1'b1;
            bus.sub_rdata[127:96] = 32'h5A5A_0003;
         end
         #1;
         n_cmp++; if (bus.mgr_gnt !== 2'b00) begin n_err++; $display("FAIL st_stall_gnt[%0d]: got %b want 00", i, bus.mgr_gnt); end
         n_cmp++; if (bus.sub_req !== 4'b0000) begin n_err++; $display("FAIL st_stall_req[%0d]: got %b want 0000", i, bus.sub_req); end
      end
      n_cmp++; if (bus.mgr_rvalid !== 2'b01) begin n_err++; $display("FAIL st_sram_rvalid: got %b want 01", bus.mgr_rvalid); end
      n_cmp++; if (bus.mgr_rdata[31:0] !== 32'h5A5A_0003) begin n_err++; $display("FAIL st_sram_rdata: got %h want 5a5a0003", bus.mgr_rdata[31:0]); end
      @(negedge clk);
      idle();
      bus.mgr_req[0] = 1'b1;
      bus.mgr_addr[31:0] = 32'h2000_0040;
      bus.sub_gnt = 4'b0100;
      #1;
      n_cmp++; if (bus.mgr_gnt !== 2'b01) begin n_err++; $display("FAIL st_flash_gnt: got %b want 01", bus.mgr_gnt); end
      n_cmp++; if (bus.sub_req !== 4'b0100) begin n_err++; $display("FAIL st_flash_req: got %b want 0100", bus.sub_req); end
      @(negedge clk);
      idle();
      bus.sub_rvalid[2] = 1'b1;
      bus.sub_rdata[95:64] = 32'h0000_00F1;
      #1;
      n_cmp++; if (bus.mgr_rvalid !== 2'b01) begin n_err++; $display("FAIL st_flash_rvalid: got %b want 01", bus.mgr_rvalid); end
   endtask

   task automatic test_unmapped();
      @(negedge clk);
      idle();
      bus.mgr_req[1] = 1'b1;
      bus.mgr_addr[63:32] = 32'h5000_0000;
      bus.sub_gnt = 4'hF;
      #1;
      n_cmp++; if (bus.sub_req !== 4'h0) begin n_err++; $display("FAIL um_sub_req: got %b want 0000", bus.sub_req); end
`ifdef OBI_XBAR_ERR_RESP_EN
      n_cmp++; if (bus.mgr_gnt !== 2'b10) begin n_err++; $display("FAIL um_gnt: got %b want 10", bus.mgr_gnt); end
      n_cmp++; if (bus.mgr_rvalid !== 2'b00) begin n_err++; $display("FAIL um_rvalid_early: got %b want 00", bus.mgr_rvalid); end
      @(negedge clk);
      idle();
      #1;
      n_cmp++; if (bus.mgr_rvalid !== 2'b10) begin n_err++; $display("FAIL um_rvalid: got %b want 10", bus.mgr_rvalid); end
      n_cmp++; if (bus.mgr_err !== 2'b10) begin n_err++; $display("FAIL um_err: got %b want 10", bus.mgr_err); end
      n_cmp++; if (bus.mgr_rdata !== 64'h0) begin n_err++; $display("FAIL um_rdata: got %h want 0", bus.mgr_rdata); end
      @(negedge clk);
      idle();
      #1;
      n_cmp++; if (bus.mgr_err !== 2'b00) begin n_err++; $display("FAIL um_err_after: got %b want 00", bus.mgr_err); end
`else
      n_cmp++; if (bus.mgr_gnt !== 2'b00) begin n_err++; $display("FAIL um_gnt: got %b want 00", bus.mgr_gnt); end
      n_cmp++; if (bus.illegal_access !== 1'b1) begin n_err++; $display("FAIL um_illegal: got %b want 1", bus.illegal_access); end
      @(negedge clk);
      #1;
      n_cmp++; if (bus.mgr_gnt !== 2'b00) begin n_err++; $display("FAIL um_gnt_hold: got %b want 00", bus.mgr_gnt); end
      n_cmp++; if (bus.illegal_access !== 1'b1) begin n_err++; $display("FAIL um_illegal_hold: got %b want 1", bus.illegal_access); end
      n_cmp++; if (bus.mgr_err !== 2'b00) begin n_err++; $display("FAIL um_err: got %b want 00", bus.mgr_err); end
      @(negedge clk);
      idle();
      #1;
      n_cmp++; if (bus.illegal_access !== 1'b0) begin n_err++; $display("FAIL um_illegal_clear: got %b want 0", bus.illegal_access); end
`endif
   endtask

   task automatic test_spurious();
      @(negedge clk);
      idle();
      bus.sub_rvalid[1] = 1'b1;
      bus.sub_rdata[63:32] = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (bus.illegal_access !== 1'b1) begin n_err++; $display("FAIL sp_illegal: got %b want 1", bus.illegal_access); end
      n_cmp++; if (bus.mgr_rvalid !== 2'b00) begin n_err++; $display("FAIL sp_rvalid: got %b want 00", bus.mgr_rvalid); end
      n_cmp++; if (bus.mgr_rdata !== 64'h0) begin n_err++; $display("FAIL sp_rdata: got %h want 0", bus.mgr_rdata); end
      @(negedge clk);
      idle();
      #1;
      n_cmp++; if (bus.illegal_access !== 1'b0) begin n_err++; $display("FAIL sp_pulse_end: got %b want 0", bus.illegal_access); end
   endtask

   task automatic test_reset_midflight();
      @(negedge clk);
      idle();
      bus.mgr_req = 2'b11;
      bus.mgr_addr = {32'h2000_0200, 32'h8000_0030};
      bus.sub_gnt = 4'b1100;
      #1;
      n_cmp++; if (bus.mgr_gnt !== 2'b11) begin n_err++; $display("FAIL mr_gnt: got %b want 11", bus.mgr_gnt); end
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      bus.sub_rvalid = 4'b1100;
      bus.sub_rdata = {32'h1, 32'h2, 64'h0};
      #1;
      n_cmp++; if (bus.mgr_rvalid !== 2'b00) begin n_err++; $display("FAIL mr_rst_rvalid: got %b want 00", bus.mgr_rvalid); end
      n_cmp++; if (bus.mgr_rdata !== 64'h0) begin n_err++; $display("FAIL mr_rst_rdata: got %h want 0", bus.mgr_rdata); end
      n_cmp++; if (bus.illegal_access !== 1'b0) begin n_err++; $display("FAIL mr_rst_illegal: got %b want 0", bus.illegal_access); end
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      bus.sub_rvalid[3] = 1'b1;
      #1;
      n_cmp++; if (bus.illegal_access !== 1'b1) begin n_err++; $display("FAIL mr_late_illegal: got %b want 1", bus.illegal_access); end
      n_cmp++; if (bus.mgr_rvalid !== 2'b00) begin n_err++; $display("FAIL mr_late_rvalid: got %b want 00", bus.mgr_rvalid); end
      @(negedge clk);
      idle();
      bus.mgr_req[0] = 1'b1;
      bus.mgr_addr[31:0] = 32'h2000_0300;
      bus.sub_gnt = 4'b0100;
      #1;
      n_cmp++; if (bus.mgr_gnt !== 2'b01) begin n_err++; $display("FAIL mr_cnt_clear_gnt: got %b want 01", bus.mgr_gnt); end
      @(negedge clk);
      idle();
      bus.sub_rvalid[2] = 1'b1;
      bus.sub_rdata[95:64] = 32'h0000_0077;
      #1;
      n_cmp++; if (bus.mgr_rvalid !== 2'b01) begin n_err++; $display("FAIL mr_post_rvalid: got %b want 01", bus.mgr_rvalid); end
      n_cmp++; if (bus.mgr_rdata[31:0] !== 32'h0000_0077) begin n_err++; $display("FAIL mr_post_rdata: got %h want 77", bus.mgr_rdata[31:0]); end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_single_read();
      test_decode_bounds();
      test_contention();
      test_order_stall();
      test_unmapped();
      test_spurious();
      test_reset_midflight();
      @(negedge clk);
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
